// File: rtl/vga_rect_fill_pkg.sv
// Shared constants and types for the rectangle fill engine and its neighbours
// (VGA scan-out, CPU decode).
package vga_rect_fill_pkg;

  localparam int unsigned H_PIX         = 160;
  localparam int unsigned V_PIX         = 120;
  localparam int unsigned WORDS_PER_ROW = H_PIX / 4;
  localparam int unsigned ADDR_W        = 13;

  localparam logic [1:0] REG_XY    = 2'd0;
  localparam logic [1:0] REG_WH    = 2'd1;
  localparam logic [1:0] REG_COLOR = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLIP,
    S_WRITE,
    S_DONE
  } fill_state_t;

  function automatic logic [31:0] splat_color(input logic [7:0] c);
    return {4{c}};
  endfunction

endpackage

// File: rtl/vga_rect_fill_if.sv
// VRAM write channel: the fill engine drives it, the VRAM write port accepts it.
interface vga_rect_fill_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              vram_we;
    logic [ADDR_W-1:0] vram_waddr;
    logic [31:0]       vram_wdata;
    logic [3:0]        vram_wmask;
    logic              vram_wready;

    modport master (
        output vram_we,
        output vram_waddr,
        output vram_wdata,
        output vram_wmask,
        input  vram_wready
    );

    modport slave (
        input  vram_we,
        input  vram_waddr,
        input  vram_wdata,
        input  vram_wmask,
        output vram_wready
    );
endinterface

// File: rtl/vga_span_mask.sv
// Byte-enable mask for one 4-pixel VRAM word: bit i is set when pixel
// word_idx*4+i lies inside the inclusive span [x_first, x_last].
module vga_span_mask (
    input  logic [15:0] x_first,
    input  logic [15:0] x_last,
    input  logic [13:0] word_idx,
    output logic [3:0]  mask
);
    logic [15:0] px;

    always_comb begin
        mask = '0;
        px   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            px      = {word_idx, 2'(i)};
            mask[i] = (px >= x_first) && (px <= x_last);
        end
    end
endmodule

// File: rtl/vga_rect_fill.sv
// CPU-programmed rectangle fill engine: clips the programmed rectangle to the
// screen and streams masked 4-pixel words into VRAM, one per accepted cycle.
module vga_rect_fill #(
    parameter int unsigned H_PIX  = vga_rect_fill_pkg::H_PIX,
    parameter int unsigned V_PIX  = vga_rect_fill_pkg::V_PIX,
    parameter int unsigned ADDR_W = vga_rect_fill_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_addr,
    input  logic [31:0]             cfg_wdata,
    output logic [31:0]             cfg_rdata,
    vga_rect_fill_if.master         vram,
    output logic                    done_pulse
);
    import vga_rect_fill_pkg::*;

    localparam int unsigned WPR = H_PIX / 4;

    logic [15:0] x0_r, y0_r, w_r, h_r;
    logic [7:0]  color_r;

    logic [15:0] sx0, sy0, sw, sh;
    logic [7:0]  scolor;

    fill_state_t state;
    logic        busy, done;

    logic [15:0]       fx, lx, row, lrow;
    logic [13:0]       fcol, lcol, col;
    logic [ADDR_W-1:0] row_base;

    logic              start_req;
    logic [16:0]       xe_sum, ye_sum, clip_xe, clip_ye;
    logic [15:0]       clip_lx, clip_ly;
    logic              clip_empty;
    logic [ADDR_W-1:0] clip_row_base, clip_addr;
    logic              row_end, last_word;
    logic [13:0]       next_col;
    logic [ADDR_W-1:0] next_row_base, next_addr;
    logic [15:0]       mx_first, mx_last;
    logic [13:0]       mword;
    logic [3:0]        span_mask;

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_XY:    cfg_rdata = {y0_r, x0_r};
            REG_WH:    cfg_rdata = {h_r, w_r};
            REG_COLOR: cfg_rdata = {24'd0, color_r};
            REG_CTRL:  cfg_rdata = {30'd0, done, busy};
            default:   cfg_rdata = '0;
        endcase
    end

    assign start_req = cfg_we && (cfg_addr == REG_CTRL) && cfg_wdata[0];

    // Clip arithmetic is 17 bits wide so X0+W / Y0+H never wrap back on-screen.
    always_comb begin
        xe_sum        = {1'b0, sx0} + {1'b0, sw};
        ye_sum        = {1'b0, sy0} + {1'b0, sh};
        clip_xe       = (xe_sum > 17'(H_PIX)) ? 17'(H_PIX) : xe_sum;
        clip_ye       = (ye_sum > 17'(V_PIX)) ? 17'(V_PIX) : ye_sum;
        clip_lx       = 16'(clip_xe - 17'd1);
        clip_ly       = 16'(clip_ye - 17'd1);
        clip_empty    = (sw == '0) || (sh == '0) ||
                        (sx0 >= 16'(H_PIX)) || (sy0 >= 16'(V_PIX));
        clip_row_base = ADDR_W'(sy0) * ADDR_W'(WPR);
        clip_addr     = clip_row_base + ADDR_W'(sx0[15:2]);
    end

    always_comb begin
        row_end       = (col == lcol);
        last_word     = row_end && (row == lrow);
        next_col      = row_end ? fcol : col + 14'd1;
        next_row_base = row_end ? row_base + ADDR_W'(WPR) : row_base;
        next_addr     = next_row_base + ADDR_W'(next_col);
    end

    // The one mask generator serves both the first word (from CLIP) and every following word.
    always_comb begin
        if (state == S_CLIP) begin
            mx_first = sx0;
            mx_last  = clip_lx;
            mword    = sx0[15:2];
        end else begin
            mx_first = fx;
            mx_last  = lx;
            mword    = next_col;
        end
    end

    vga_span_mask u_span_mask (
        .x_first  (mx_first),
        .x_last   (mx_last),
        .word_idx (mword),
        .mask     (span_mask)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_r            <= '0;
            y0_r            <= '0;
            w_r             <= '0;
            h_r             <= '0;
            color_r         <= '0;
            sx0             <= '0;
            sy0             <= '0;
            sw              <= '0;
            sh              <= '0;
            scolor          <= '0;
            state           <= S_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            done_pulse      <= 1'b0;
            fx              <= '0;
            lx              <= '0;
            row             <= '0;
            lrow            <= '0;
            fcol            <= '0;
            lcol            <= '0;
            col             <= '0;
            row_base        <= '0;
            vram.vram_we    <= 1'b0;
            vram.vram_waddr <= '0;
            vram.vram_wdata <= '0;
            vram.vram_wmask <= '0;
        end else begin
            done_pulse <= 1'b0;

            if (cfg_we) begin
                case (cfg_addr)
                    REG_XY:    {y0_r, x0_r} <= cfg_wdata;
                    REG_WH:    {h_r, w_r}   <= cfg_wdata;
                    REG_COLOR: color_r      <= cfg_wdata[7:0];
                    REG_CTRL:  if (cfg_wdata[1]) done <= 1'b0;
                    default:   ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        sx0    <= x0_r;
                        sy0    <= y0_r;
                        sw     <= w_r;
                        sh     <= h_r;
                        scolor <= color_r;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        state  <= S_CLIP;
                    end
                end
                S_CLIP: begin
                    if (clip_empty) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        done_pulse <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        fx              <= sx0;
                        lx              <= clip_lx;
                        fcol            <= sx0[15:2];
                        lcol            <= clip_lx[15:2];
                        col             <= sx0[15:2];
                        row             <= sy0;
                        lrow            <= clip_ly;
                        row_base        <= clip_row_base;
                        vram.vram_we    <= 1'b1;
                        vram.vram_waddr <= clip_addr;
                        vram.vram_wdata <= splat_color(scolor);
                        vram.vram_wmask <= span_mask;
                        state           <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (vram.vram_we && vram.vram_wready) begin
                        if (last_word) begin
                            vram.vram_we <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            done_pulse   <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            col             <= next_col;
                            row_base        <= next_row_base;
                            if (row_end) row <= row + 16'd1;
                            vram.vram_waddr <= next_addr;
                            vram.vram_wmask <= span_mask;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
